// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {PC, PCPlus4, Instr} tuples between fetch and decode.
// Occupancy alone distinguishes full from empty; Flush empties the queue, and rst takes priority over Flush.
module fetch_queue #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [D_WIDTH-1:0]       PCF,
  input  logic [D_WIDTH-1:0]       PCPlus4F,
  input  logic [D_WIDTH-1:0]       InstrF,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [D_WIDTH-1:0]       PCD,
  output logic [D_WIDTH-1:0]       PCPlus4D,
  output logic [D_WIDTH-1:0]       InstrD,
  output logic                     StallF,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 * D_WIDTH;
  localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
  localparam logic [D_WIDTH-1:0] NOP      = D_WIDTH'(32'h0000_0013);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head_s;
  logic          push_s, pop_s;

  always_comb begin
    InReady  = (cnt_q != CNT_FULL);
    OutValid = (cnt_q != {CW{1'b0}});
    StallF   = ~InReady;
    Count    = cnt_q;
    push_s   = InValid & InReady & ~Flush;
    pop_s    = OutValid & OutReady & ~Flush;
    head_s   = mem_q[rd_ptr_q];
    if (OutValid) begin
      PCD      = head_s[EW-1 -: D_WIDTH];
      PCPlus4D = head_s[2*D_WIDTH-1 -: D_WIDTH];
      InstrD   = head_s[D_WIDTH-1:0];
    end else begin
      PCD      = {D_WIDTH{1'b0}};
      PCPlus4D = {D_WIDTH{1'b0}};
      InstrD   = NOP;
    end
  end

  // Flush clears pointers and occupancy; otherwise each pointer advances on its own handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (Flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      cnt_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; a write is gated by rst so that reset overrides a push.
  always_ff @(posedge CLK) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= {PCF, PCPlus4F, InstrF};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue (DEPTH=4): every expected head/occupancy value is hand-computed.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        rst, Flush, InValid, OutReady;
  logic [31:0] PCF, PCPlus4F, InstrF;
  logic        InReady, OutValid, StallF;
  logic [31:0] PCD, PCPlus4D, InstrD;
  logic [2:0]  Count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_queue #(.D_WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .rst(rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .OutValid(OutValid),
    .OutReady(OutReady), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD),
    .StallF(StallF), .Count(Count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [2:0]  e_cnt;
    logic [31:0] e_pcd;
  } vec_t;

  vec_t vecs [39];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0050_0093 ^ {pc[19:0], 12'h000};
  endfunction

  function automatic vec_t mk(input logic c, input logic r, input logic f, input logic v,
                              input logic [31:0] p, input logic o, input logic eov,
                              input logic eir, input logic [2:0] ec, input logic [31:0] ep);
    vec_t t;
    t.chk = c; t.rst = r; t.fl = f; t.iv = v; t.pc = p; t.ordy = o;
    t.e_ov = eov; t.e_ir = eir; t.e_cnt = ec; t.e_pcd = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] p,
                       input logic o);
    @(negedge CLK);
    rst = r; Flush = f; InValid = v; OutReady = o;
    PCF = p; PCPlus4F = p + 32'd4; InstrF = instr_of(p);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic ov, input logic ir,
                               input logic [2:0] cnt, input logic [31:0] pcd);
    check({tag, ".OutValid"}, {31'd0, OutValid}, {31'd0, ov});
    check({tag, ".InReady"},  {31'd0, InReady},  {31'd0, ir});
    check({tag, ".StallF"},   {31'd0, StallF},   {31'd0, ~ir});
    check({tag, ".Count"},    {29'd0, Count},    {29'd0, cnt});
    check({tag, ".PCD"},      PCD,               pcd);
    check({tag, ".PCPlus4D"}, PCPlus4D,          ov ? pcd + 32'd4 : 32'd0);
    check({tag, ".InstrD"},   InstrD,            ov ? instr_of(pcd) : 32'h0000_0013);
    check({tag, ".CountMax"}, {31'd0, (Count <= 3'd4)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    PCF = 32'd0; PCPlus4F = 32'd4; InstrF = 32'd0;

    // chk rst fl iv pc ordy | exp ov ir cnt pcd (expected state before the edge)
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd1, 32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h4,   1'b0, 1'b1, 1'b1, 3'd1, 32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h8,   1'b0, 1'b1, 1'b1, 3'd2, 32'h0);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hC,   1'b0, 1'b1, 1'b1, 3'd3, 32'h0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b1, 1'b0, 3'd4, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h10,  1'b1, 1'b1, 1'b0, 3'd4, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 3'd3, 32'h4);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd3, 32'h4);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd2, 32'h8);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 3'd1, 32'hC);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b1, 1'b1, 3'd1, 32'hC);
    for (int i = 0; i < 8; i++) begin
      vecs[17+i] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h14 + 32'(4*i), 1'b1, 1'b1, 1'b1, 3'd2,
                      32'hC + 32'(4*i));
    end
    vecs[25] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 3'd2, 32'h2C);
    vecs[26] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h34,  1'b0, 1'b1, 1'b1, 3'd2, 32'h2C);
    vecs[27] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h40,  1'b1, 1'b1, 1'b1, 3'd3, 32'h2C);
    vecs[28] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[29] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd1, 32'h80);
    vecs[30] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[31] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[32] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 3'd1, 32'h100);
    vecs[33] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 3'd2, 32'h100);
    vecs[34] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h10C, 1'b0, 1'b1, 1'b1, 3'd3, 32'h100);
    vecs[35] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 1'b1, 1'b0, 3'd4, 32'h100);
    vecs[36] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    vecs[37] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd1, 32'h200);
    vecs[38] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 3'd0, 32'h0);

    for (int i = 0; i < 39; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      if (vecs[i].chk) begin
        check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_cnt,
                      vecs[i].e_pcd);
      end
    end

    // Hold: head must stay put while decode stalls, then advance after one pop.
    drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h304, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_outputs($sformatf("hold%0d", k), 1'b1, 1'b1, 3'd2, 32'h300);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_outputs("after_hold", 1'b1, 1'b1, 3'd1, 32'h304);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
